// File: rtl/water_reminder_pkg.sv
// rtl/water_reminder_pkg.sv - shared types, BCD constants and BCD add helper
package water_reminder_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2,
    SET   = 2'd3
  } state_t;

  localparam logic [7:0] BCD_59   = 8'h59;
  localparam logic [7:0] BCD_ZERO = 8'h00;

  // Returns {carry_out, two BCD digits}; carry_out means the sum passed 99.
  function automatic logic [8:0] bcd_add2(input logic [7:0] a, input logic [7:0] b);
    logic [4:0] lo;
    logic [4:0] hi;
    logic       c;
    lo = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    c  = 1'b0;
    if (lo > 5'd9) begin
      lo = lo + 5'd6;
      c  = 1'b1;
    end
    hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, c};
    if (hi > 5'd9) hi = hi + 5'd6;
    return {hi[4], hi[3:0], lo[3:0]};
  endfunction

endpackage

// File: rtl/water_reminder_scheduler_bcd_down2.sv
// rtl/water_reminder_scheduler_bcd_down2.sv - 2-digit BCD decrementer with wrap value
module bcd_down2
  import water_reminder_pkg::*;
#(
  parameter logic [7:0] WRAP = 8'h00
) (
  input  logic [7:0] val,
  input  logic       dec,
  output logic [7:0] next,
  output logic       borrow
);

  always_comb begin
    next   = val;
    borrow = 1'b0;
    if (dec) begin
      if (val == BCD_ZERO) begin
        next   = WRAP;
        borrow = 1'b1;
      end else if (val[3:0] == 4'd0) begin
        next = {val[7:4] - 4'd1, 4'h9};
      end else begin
        next = {val[7:4], val[3:0] - 4'd1};
      end
    end
  end

endmodule

// File: rtl/water_reminder_scheduler.sv
// rtl/water_reminder_scheduler.sv - BCD countdown reminder FSM with alarm timeout and snooze
module water_reminder_scheduler
  import water_reminder_pkg::*;
#(
  parameter logic [7:0]  DEFAULT_MIN     = 8'h30,
  parameter logic [7:0]  STEP_MIN        = 8'h05,
  parameter logic [7:0]  MAX_MIN         = 8'h90,
  parameter logic [7:0]  SNOOZE_MIN      = 8'h05,
  parameter int unsigned ALARM_TIMEOUT_S = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_ack,
  output logic [1:0] state,
  output logic [7:0] remain_min,
  output logic [7:0] remain_sec,
  output logic [7:0] interval_min,
  output logic       alarm,
  output logic       alarm_start,
  output logic [3:0] missed
);

  state_t     state_q, state_n;
  logic [7:0] rmin_n, rsec_n, int_n;
  logic [3:0] missed_n;
  logic [6:0] age_q, age_n;
  logic [7:0] sec_next, min_next;
  logic       sec_borrow, min_borrow;
  logic [8:0] up_sum;

  bcd_down2 #(.WRAP(BCD_59)) u_sec (
    .val(remain_sec), .dec(1'b1), .next(sec_next), .borrow(sec_borrow)
  );

  // Minutes only step when seconds borrow; a borrow out of 00:00 means nothing is left.
  bcd_down2 #(.WRAP(BCD_ZERO)) u_min (
    .val(remain_min), .dec(sec_borrow), .next(min_next), .borrow(min_borrow)
  );

  assign up_sum = bcd_add2(interval_min, STEP_MIN);

  always_comb begin
    state_n  = state_q;
    rmin_n   = remain_min;
    rsec_n   = remain_sec;
    int_n    = interval_min;
    missed_n = missed;
    age_n    = age_q;
    if (!enable) begin
      state_n = OFF;
      rmin_n  = BCD_ZERO;
      rsec_n  = BCD_ZERO;
    end else begin
      case (state_q)
        OFF: begin
          if (btn_mode) begin
            state_n = SET;
          end else begin
            state_n = RUN;
            rmin_n  = interval_min;
            rsec_n  = BCD_ZERO;
          end
        end
        RUN: begin
          if (btn_mode) begin
            state_n = SET;
          end else if (tick) begin
            rmin_n = min_next;
            rsec_n = sec_next;
            if ((remain_min == BCD_ZERO && remain_sec == 8'h01) || min_borrow) begin
              rmin_n  = BCD_ZERO;
              rsec_n  = BCD_ZERO;
              state_n = ALARM;
            end
          end
        end
        ALARM: begin
          if (btn_mode) begin
            state_n = SET;
          end else if (btn_ack) begin
            state_n = RUN;
            rmin_n  = interval_min;
            rsec_n  = BCD_ZERO;
          end else if (tick) begin
            if (age_q == 7'(ALARM_TIMEOUT_S - 1)) begin
              missed_n = (missed == 4'd9) ? 4'd9 : missed + 4'd1;
              state_n  = RUN;
              rmin_n   = SNOOZE_MIN;
              rsec_n   = BCD_ZERO;
            end else begin
              age_n = age_q + 7'd1;
            end
          end
        end
        SET: begin
          if (btn_mode) begin
            state_n = RUN;
            rmin_n  = interval_min;
            rsec_n  = BCD_ZERO;
          end else if (btn_up) begin
            int_n = (up_sum[8] || up_sum[7:0] > MAX_MIN) ? STEP_MIN : up_sum[7:0];
          end
        end
        default: state_n = OFF;
      endcase
    end
    if (state_n != ALARM) age_n = 7'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= OFF;
      remain_min   <= BCD_ZERO;
      remain_sec   <= BCD_ZERO;
      interval_min <= DEFAULT_MIN;
      missed       <= 4'd0;
      age_q        <= 7'd0;
      alarm        <= 1'b0;
      alarm_start  <= 1'b0;
    end else begin
      state_q      <= state_n;
      remain_min   <= rmin_n;
      remain_sec   <= rsec_n;
      interval_min <= int_n;
      missed       <= missed_n;
      age_q        <= age_n;
      alarm        <= (state_n == ALARM);
      alarm_start  <= (state_n == ALARM) && (state_q != ALARM);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_water_reminder_scheduler.sv
// tb/tb_water_reminder_scheduler.sv - self-checking bench with seconds-based reference model
module tb_water_reminder_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_ack = 1'b0;
  logic [1:0] state;
  logic [7:0] remain_min, remain_sec, interval_min;
  logic       alarm, alarm_start;
  logic [3:0] missed;

  int errors = 0;
  int checks = 0;

  water_reminder_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_ack(btn_ack),
    .state(state), .remain_min(remain_min), .remain_sec(remain_sec),
    .interval_min(interval_min), .alarm(alarm), .alarm_start(alarm_start),
    .missed(missed)
  );

  always #5 clk = ~clk;

  // Model keeps the remaining time as plain seconds and the interval as decimal minutes.
  typedef struct {
    int st;
    int rem;
    int itv;
    int mis;
    int age;
    bit start;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.st = 0; r.rem = 0; r.itv = 30; r.mis = 0; r.age = 0; r.start = 1'b0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t c, input logic en, input logic md,
                                        input logic up, input logic ak, input logic tk);
    model_t r;
    r = c;
    if (!en) begin
      r.st = 0; r.rem = 0;
    end else if (c.st == 0) begin
      if (md) r.st = 3;
      else begin r.st = 1; r.rem = c.itv * 60; end
    end else if (c.st == 1) begin
      if (md) r.st = 3;
      else if (tk) begin
        if (c.rem <= 1) begin r.rem = 0; r.st = 2; end
        else r.rem = c.rem - 1;
      end
    end else if (c.st == 2) begin
      if (md) r.st = 3;
      else if (ak) begin r.st = 1; r.rem = c.itv * 60; end
      else if (tk) begin
        r.age = c.age + 1;
        if (r.age == 60) begin
          r.mis = (c.mis + 1 > 9) ? 9 : c.mis + 1;
          r.rem = 5 * 60;
          r.st  = 1;
        end
      end
    end else begin
      if (md) begin r.st = 1; r.rem = c.itv * 60; end
      else if (up) r.itv = (c.itv + 5 > 90) ? 5 : c.itv + 5;
    end
    if (r.st != 2) r.age = 0;
    r.start = (r.st == 2) && (c.st != 2);
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= model_reset();
    else       m <= model_next(m, enable, btn_mode, btn_up, btn_ack, tick);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_state",    32'(state),        32'(m.st));
      chk("model_rem_min",  32'(remain_min),   32'(to_bcd(m.rem / 60)));
      chk("model_rem_sec",  32'(remain_sec),   32'(to_bcd(m.rem % 60)));
      chk("model_interval", 32'(interval_min), 32'(to_bcd(m.itv)));
      chk("model_alarm",    32'(alarm),        32'(m.st == 2));
      chk("model_start",    32'(alarm_start),  32'(m.start));
      chk("model_missed",   32'(missed),       32'(m.mis));
    end
  end

  task automatic step(input logic md, input logic up, input logic ak, input logic tk);
    btn_mode = md; btn_up = up; btn_ack = ak; tick = tk;
    @(negedge clk);
    btn_mode = 1'b0; btn_up = 1'b0; btn_ack = 1'b0; tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_remain(input string name, input logic [15:0] exp);
    chk(name, 32'({remain_min, remain_sec}), 32'(exp));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_interval", 32'(interval_min), 32'h30);
    chk_remain("reset_remain", 16'h0000);

    enable = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("run_state", 32'(state), 32'd1);
    chk_remain("load_30", 16'h3000);
    ticks(1);
    chk_remain("first_tick", 16'h2959);
    ticks(599);
    chk_remain("after_600", 16'h2000);
    ticks(600);
    chk_remain("at_10_00", 16'h1000);
    ticks(1);
    chk_remain("min_borrow", 16'h0959);
    ticks(589);
    chk_remain("at_00_10", 16'h0010);
    ticks(1);
    chk_remain("sec_decade", 16'h0009);
    ticks(8);
    chk_remain("at_00_01", 16'h0001);
    ticks(1);
    chk_remain("alarm_zero", 16'h0000);
    chk("alarm_state", 32'(state), 32'd2);
    chk("alarm_start_hi", 32'(alarm_start), 32'd1);
    chk("alarm_hi", 32'(alarm), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("alarm_start_lo", 32'(alarm_start), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ack_state", 32'(state), 32'd1);
    chk_remain("ack_reload", 16'h3000);
    chk("ack_missed", 32'(missed), 32'd0);

    ticks(1800);
    chk("alarm2_state", 32'(state), 32'd2);
    ticks(59);
    chk("pre_timeout", 32'(state), 32'd2);
    ticks(1);
    chk("timeout_missed", 32'(missed), 32'd1);
    chk_remain("snooze_reload", 16'h0500);

    ticks(300);
    ticks(59);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("race_state", 32'(state), 32'd1);
    chk("race_missed", 32'(missed), 32'd1);
    chk_remain("race_reload", 16'h3000);

    ticks(1800);
    for (int i = 0; i < 10; i++) begin
      ticks(60);
      if (i < 9) ticks(300);
    end
    chk("missed_sat", 32'(missed), 32'd9);
    chk_remain("sat_snooze", 16'h0500);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("set_state", 32'(state), 32'd3);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("set_85", 32'(interval_min), 32'h85);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("set_90", 32'(interval_min), 32'h90);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("set_wrap", 32'(interval_min), 32'h05);
    ticks(3);
    chk_remain("set_frozen", 16'h0500);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("set_exit", 32'(state), 32'd1);

    enable = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("off_wins", 32'(state), 32'd0);
    chk_remain("off_clear", 16'h0000);
    enable = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_remain("rerun_05", 16'h0500);
    ticks(300);
    chk("alarm3_state", 32'(state), 32'd2);
    ticks(10);

    #2 reset = 1'b1;
    #1;
    chk("areset_state", 32'(state), 32'd0);
    chk("areset_alarm", 32'(alarm), 32'd0);
    chk("areset_missed", 32'(missed), 32'd0);
    chk("areset_interval", 32'(interval_min), 32'h30);
    chk_remain("areset_remain", 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_remain("post_reset_run", 16'h3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
